decode_issue_queue: RTL and testbench
=====================================

Name: decode_issue_queue

Overview:
- Parametrised successor to the single-register decode stage.
- Buffers decoded instruction packets in a DEPTH-entry FIFO between the instruction decoder and the execution stage.
- Tracks pending register writes in a scoreboard and issues the head packet only when it has no RAW/WAW hazard.
- Uses valid/ready handshakes on both sides and replaces the register-file stall signal with an explicit hazard stall.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- PAYLOAD_W, 128, width of the opaque decoded packet (ops, immediate, operand data, pc, flags).
- NUM_REGS, 32, architectural integer registers; REG_AW = $clog2(NUM_REGS), derived.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-low.
- enq_valid_i  in  1  decoder presents a packet.
- enq_ready_o  out  1  queue can accept; equals !full.
- enq_payload_i  in  PAYLOAD_W  decoded packet.
- enq_rs1_i  in  REG_AW  source register 1.
- enq_rs1_used_i  in  1  rs1 is read.
- enq_rs2_i  in  REG_AW  source register 2.
- enq_rs2_used_i  in  1  rs2 is read.
- enq_rd_i  in  REG_AW  destination register.
- enq_rd_write_i  in  1  instruction writes rd.
- iss_valid_o  out  1  head packet is issuable.
- iss_ready_i  in  1  execution stage accepts.
- iss_payload_o  out  PAYLOAD_W  head packet payload.
- iss_rd_o  out  REG_AW  head destination register.
- iss_rd_write_o  out  1  head writes rd.
- wb_valid_i  in  1  write-back retires a register write.
- wb_rd_i  in  REG_AW  retiring destination register.
- stall_i  in  1  pipeline-controller stall; blocks issue.
- flush_i  in  1  discard all queued packets.
- flush_scoreboard_i  in  1  clear all pending bits (exception/mret).
- count_o  out  $clog2(DEPTH+1)  occupancy.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == DEPTH.
- hazard_stall_o  out  1  head valid but blocked by a hazard.

Behaviour:
- Reset (rst_i low, async):
  - rd_ptr, wr_ptr, count and scoreboard cleared to 0.
  - enq_ready_o=1, iss_valid_o=0, empty_o=1, full_o=0, hazard_stall_o=0, count_o=0.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards everything immediately.
- Enqueue: fires on enq_valid_i && enq_ready_o && !flush_i; writes entry[wr_ptr], then wr_ptr++.
  - enq_ready_o = !full_o, with no combinational dependence on iss_ready_i. When full, a same-cycle dequeue does not admit an enqueue.
- No bypass: a packet enqueued in cycle N can first present iss_valid_o in cycle N+1.
- Pointers are log2(DEPTH) bits and wrap naturally; count tracks occupancy. Simultaneous enqueue and issue leaves count unchanged.
- Scoreboard sb[NUM_REGS-1:0]:
  - Effective view sb_eff = sb & ~(wb_valid_i ? onehot(wb_rd_i) : 0). A write-back releases its register in the same cycle.
  - hazard = (rs1_used && rs1!=0 && sb_eff[rs1]) || (rs2_used && rs2!=0 && sb_eff[rs2]) || (rd_write && rd!=0 && sb_eff[rd]), evaluated on the head entry.
- Issue outputs:
  - iss_valid_o = !empty && !hazard && !stall_i && !flush_i.
  - Transfer when iss_valid_o && iss_ready_i: rd_ptr++ and, if rd_write && rd!=0, sb[rd] is set next edge.
  - iss_payload_o, iss_rd_o and iss_rd_write_o are driven combinationally from entry[rd_ptr]; they are stable while iss_valid_o=1 and iss_ready_i=0.
- hazard_stall_o = !empty && hazard. It is independent of stall_i and iss_ready_i.
- Scoreboard update priority per bit: flush_scoreboard_i clear > issue set > write-back clear.
  - Register x0 is never set.
  - wb on a non-pending register has no effect.
- flush_i: next edge sets rd_ptr=wr_ptr=count=0. Enqueue and issue are both suppressed in the flush cycle. The scoreboard is untouched unless flush_scoreboard_i is also asserted.
- stall_i: freezes issue only. Enqueue continues while space remains.

Decomposition:
- Shared package decode_pkg: REG_AW helper, reg-index typedef, X0 constant, onehot-decode function. PAYLOAD_W default is placed alongside the existing decode packet field widths.
- One natural sub-module, reg_scoreboard: holds sb, the same-cycle wb bypass, the hazard compare and set/clear priority.
- FIFO storage and pointers stay in the top level.

Test Plan:
- Fill/drain: DEPTH=4, iss_ready_i=0, enqueue 5 packets (payload 1..5) -> 4 accepted, full_o=1, enq_ready_o=0; then iss_ready_i=1 -> payloads 1,2,3,4 in order, one per cycle, empty_o=1 after the 4th.
- RAW: issue rd=5, then head reads rs1=5 -> hazard_stall_o=1, iss_valid_o=0; wb_valid_i=1, wb_rd_i=5 -> iss_valid_o=1 in that same cycle.
- x0 and WAW: issue rd=0, next head rs1=0 -> no hazard; issue rd=7, next head rd=7 -> hazard until wb rd=7.
- Same-cycle set/clear: sb[9] pending, head rd=9 with wb rd=9 in the same cycle -> issues, and sb[9]=1 afterwards.
- Flush: 3 queued packets, flush_i=1 together with enq_valid_i=1 -> next cycle count_o=0 and iss_valid_o=0; sb unchanged. flush_scoreboard_i=1 -> all bits 0.
- Async reset mid-traffic: drop rst_i between clock edges with count=3 and sb[4]=1 -> outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode types and helpers.
// Packet widths, register index type, onehot decode.
package decode_pkg;

  localparam int PAYLOAD_W = 128;
  localparam int NUM_REGS  = 32;

  function automatic int reg_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int REG_AW = reg_aw(NUM_REGS);

  typedef logic [REG_AW-1:0] reg_idx_t;

  localparam reg_idx_t X0 = '0;

  function automatic logic [NUM_REGS-1:0] onehot(
    input reg_idx_t r
  );
    onehot    = '0;
    onehot[r] = 1'b1;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard with same-cycle write-back release.
// Priority per bit: clear-all > issue set > write-back clear.
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic              rs1_used_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic              rs2_used_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              rd_write_i,
  input  logic              set_i,
  input  logic              wb_valid_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              clear_i,
  output logic              hazard_o
);

  logic [NUM_REGS-1:0] sb;
  logic [NUM_REGS-1:0] sb_eff;
  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic                rd_live;

  assign rd_live = rd_write_i && (rd_i != '0);

  // Decode write-back release and issue set masks.
  always_comb begin
    wb_mask  = '0;
    set_mask = '0;
    if (wb_valid_i)
      wb_mask[wb_rd_i] = 1'b1;
    if (set_i && rd_live)
      set_mask[rd_i] = 1'b1;
  end

  assign sb_eff = sb & ~wb_mask;

  // Head hazard against the released view; x0 never conflicts.
  always_comb begin
    hazard_o = 1'b0;
    if (rs1_used_i && rs1_i != '0 && sb_eff[rs1_i])
      hazard_o = 1'b1;
    if (rs2_used_i && rs2_i != '0 && sb_eff[rs2_i])
      hazard_o = 1'b1;
    if (rd_live && sb_eff[rd_i])
      hazard_o = 1'b1;
  end

  // Pending bits: clear-all wins, set beats write-back clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      sb <= '0;
    else if (clear_i)
      sb <= '0;
    else
      sb <= sb_eff | set_mask;
  end

endmodule

// File: rtl/decode_issue_queue.sv
// Decode-to-execute issue FIFO with hazard-gated head issue.
// Storage and pointers here; pending writes in reg_scoreboard.
module decode_issue_queue
  import decode_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = decode_pkg::PAYLOAD_W,
  parameter int NUM_REGS  = decode_pkg::NUM_REGS,
  localparam int REG_AW   = reg_aw(NUM_REGS),
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enq_valid_i,
  output logic                 enq_ready_o,
  input  logic [PAYLOAD_W-1:0] enq_payload_i,
  input  logic [REG_AW-1:0]    enq_rs1_i,
  input  logic                 enq_rs1_used_i,
  input  logic [REG_AW-1:0]    enq_rs2_i,
  input  logic                 enq_rs2_used_i,
  input  logic [REG_AW-1:0]    enq_rd_i,
  input  logic                 enq_rd_write_i,
  output logic                 iss_valid_o,
  input  logic                 iss_ready_i,
  output logic [PAYLOAD_W-1:0] iss_payload_o,
  output logic [REG_AW-1:0]    iss_rd_o,
  output logic                 iss_rd_write_o,
  input  logic                 wb_valid_i,
  input  logic [REG_AW-1:0]    wb_rd_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 flush_scoreboard_i,
  output logic [CW-1:0]        count_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 hazard_stall_o
);

  logic [PAYLOAD_W-1:0] pay_q [DEPTH];
  logic [REG_AW-1:0]    rs1_q [DEPTH];
  logic [REG_AW-1:0]    rs2_q [DEPTH];
  logic [REG_AW-1:0]    rd_q  [DEPTH];
  logic [DEPTH-1:0]     u1_q;
  logic [DEPTH-1:0]     u2_q;
  logic [DEPTH-1:0]     w_q;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          hazard;
  logic          enq_fire;
  logic          iss_fire;

  assign count_o     = count;
  assign empty_o     = (count == '0);
  assign full_o      = (count == CW'(DEPTH));
  assign enq_ready_o = !full_o;

  assign enq_fire = enq_valid_i && !full_o && !flush_i;

  assign iss_valid_o = !empty_o && !hazard &&
                       !stall_i && !flush_i;
  assign iss_fire    = iss_valid_o && iss_ready_i;

  assign hazard_stall_o = !empty_o && hazard;

  assign iss_payload_o  = pay_q[rd_ptr];
  assign iss_rd_o       = rd_q[rd_ptr];
  assign iss_rd_write_o = w_q[rd_ptr];

  // Packet storage; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      pay_q[wr_ptr] <= enq_payload_i;
      rs1_q[wr_ptr] <= enq_rs1_i;
      rs2_q[wr_ptr] <= enq_rs2_i;
      rd_q[wr_ptr]  <= enq_rd_i;
      u1_q[wr_ptr]  <= enq_rs1_used_i;
      u2_q[wr_ptr]  <= enq_rs2_used_i;
      w_q[wr_ptr]   <= enq_rd_write_i;
    end
  end

  // Pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire)
        wr_ptr <= wr_ptr + 1'b1;
      if (iss_fire)
        rd_ptr <= rd_ptr + 1'b1;
      if (enq_fire && !iss_fire)
        count <= count + 1'b1;
      else if (!enq_fire && iss_fire)
        count <= count - 1'b1;
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rs1_i      (rs1_q[rd_ptr]),
    .rs1_used_i (u1_q[rd_ptr]),
    .rs2_i      (rs2_q[rd_ptr]),
    .rs2_used_i (u2_q[rd_ptr]),
    .rd_i       (rd_q[rd_ptr]),
    .rd_write_i (w_q[rd_ptr]),
    .set_i      (iss_fire),
    .wb_valid_i (wb_valid_i),
    .wb_rd_i    (wb_rd_i),
    .clear_i    (flush_scoreboard_i),
    .hazard_o   (hazard)
  );

endmodule

// File: tb/tb_decode_issue_queue.sv
// Bench for decode_issue_queue: directed steps then random traffic.
// Expected values come from a queue-and-pending-set model.
module tb_decode_issue_queue;

  localparam int PW = 128;
  localparam int RW = 5;
  localparam int QD = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          enq_valid_i;
  logic          enq_ready_o;
  logic [PW-1:0] enq_payload_i;
  logic [RW-1:0] enq_rs1_i;
  logic          enq_rs1_used_i;
  logic [RW-1:0] enq_rs2_i;
  logic          enq_rs2_used_i;
  logic [RW-1:0] enq_rd_i;
  logic          enq_rd_write_i;
  logic          iss_valid_o;
  logic          iss_ready_i;
  logic [PW-1:0] iss_payload_o;
  logic [RW-1:0] iss_rd_o;
  logic          iss_rd_write_o;
  logic          wb_valid_i;
  logic [RW-1:0] wb_rd_i;
  logic          stall_i;
  logic          flush_i;
  logic          flush_scoreboard_i;
  logic [2:0]    count_o;
  logic          empty_o;
  logic          full_o;
  logic          hazard_stall_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [PW-1:0] pl;
    int            rs1;
    bit            u1;
    int            rs2;
    bit            u2;
    int            rd;
    bit            w;
  } pkt_t;

  pkt_t q[$];
  bit   pend[32];

  always #5 clk_i = ~clk_i;

  decode_issue_queue dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .enq_valid_i        (enq_valid_i),
    .enq_ready_o        (enq_ready_o),
    .enq_payload_i      (enq_payload_i),
    .enq_rs1_i          (enq_rs1_i),
    .enq_rs1_used_i     (enq_rs1_used_i),
    .enq_rs2_i          (enq_rs2_i),
    .enq_rs2_used_i     (enq_rs2_used_i),
    .enq_rd_i           (enq_rd_i),
    .enq_rd_write_i     (enq_rd_write_i),
    .iss_valid_o        (iss_valid_o),
    .iss_ready_i        (iss_ready_i),
    .iss_payload_o      (iss_payload_o),
    .iss_rd_o           (iss_rd_o),
    .iss_rd_write_o     (iss_rd_write_o),
    .wb_valid_i         (wb_valid_i),
    .wb_rd_i            (wb_rd_i),
    .stall_i            (stall_i),
    .flush_i            (flush_i),
    .flush_scoreboard_i (flush_scoreboard_i),
    .count_o            (count_o),
    .empty_o            (empty_o),
    .full_o             (full_o),
    .hazard_stall_o     (hazard_stall_o)
  );

  task automatic check(input string tag,
                       input logic [PW-1:0] obs,
                       input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // A register is still busy unless it retires this cycle.
  function automatic bit busy(input int r);
    if (r == 0) return 1'b0;
    if (wb_valid_i && int'(wb_rd_i) == r) return 1'b0;
    return pend[r];
  endfunction

  function automatic bit m_hazard();
    pkt_t h;
    if (q.size() == 0) return 1'b0;
    h = q[0];
    return (h.u1 && busy(h.rs1)) ||
           (h.u2 && busy(h.rs2)) ||
           (h.w  && busy(h.rd));
  endfunction

  function automatic bit m_valid();
    return q.size() > 0 && !m_hazard() &&
           !stall_i && !flush_i;
  endfunction

  task automatic compare();
    bit v;
    v = m_valid();
    check("count", PW'(count_o), PW'(q.size()));
    check("empty", PW'(empty_o), PW'(q.size() == 0));
    check("full", PW'(full_o), PW'(q.size() == QD));
    check("enq_ready", PW'(enq_ready_o),
          PW'(q.size() < QD));
    check("hazard_stall", PW'(hazard_stall_o),
          PW'(q.size() > 0 && m_hazard()));
    check("iss_valid", PW'(iss_valid_o), PW'(v));
    if (v) begin
      check("iss_payload", iss_payload_o, q[0].pl);
      check("iss_rd", PW'(iss_rd_o), PW'(q[0].rd));
      check("iss_rd_write", PW'(iss_rd_write_o),
            PW'(q[0].w));
    end
  endtask

  // Compare at the falling edge, then advance the model.
  task automatic cycle();
    bit   enq;
    bit   iss;
    pkt_t p;
    pkt_t h;
    #4;
    compare();
    enq = enq_valid_i && q.size() < QD && !flush_i;
    iss = m_valid() && iss_ready_i;
    p.pl  = enq_payload_i;
    p.rs1 = int'(enq_rs1_i);
    p.u1  = enq_rs1_used_i;
    p.rs2 = int'(enq_rs2_i);
    p.u2  = enq_rs2_used_i;
    p.rd  = int'(enq_rd_i);
    p.w   = enq_rd_write_i;
    if (q.size() > 0) h = q[0];
    @(posedge clk_i);
    if (flush_scoreboard_i) begin
      foreach (pend[i]) pend[i] = 1'b0;
    end else begin
      if (wb_valid_i) pend[int'(wb_rd_i)] = 1'b0;
      if (iss && h.w && h.rd != 0) pend[h.rd] = 1'b1;
    end
    if (flush_i) begin
      q.delete();
    end else begin
      if (iss) void'(q.pop_front());
      if (enq) q.push_back(p);
    end
    #1;
  endtask

  task automatic pk(input int pl, input int rs1,
                    input bit u1, input int rs2,
                    input bit u2, input int rd,
                    input bit w);
    enq_valid_i    = 1'b1;
    enq_payload_i  = PW'(pl);
    enq_rs1_i      = RW'(rs1);
    enq_rs1_used_i = u1;
    enq_rs2_i      = RW'(rs2);
    enq_rs2_used_i = u2;
    enq_rd_i       = RW'(rd);
    enq_rd_write_i = w;
  endtask

  task automatic noenq();
    enq_valid_i = 1'b0;
  endtask

  task automatic wb(input bit v, input int r);
    wb_valid_i = v;
    wb_rd_i    = RW'(r);
  endtask

  initial begin
    rst_i              = 1'b0;
    iss_ready_i        = 1'b0;
    stall_i            = 1'b0;
    flush_i            = 1'b0;
    flush_scoreboard_i = 1'b0;
    wb(0, 0);
    pk(0, 0, 0, 0, 0, 0, 0);
    noenq();
    repeat (2) @(posedge clk_i);
    #1;
    cycle();
    rst_i = 1'b1;

    // Fill past capacity, then drain in order.
    for (int i = 1; i <= 5; i++) begin
      pk(i, 0, 0, 0, 0, 0, 0);
      cycle();
    end
    noenq();
    iss_ready_i = 1'b1;
    repeat (5) cycle();

    // RAW on x5, released by same-cycle write-back.
    pk(10, 0, 0, 0, 0, 5, 1); cycle();
    pk(11, 5, 1, 0, 0, 0, 0); cycle();
    noenq(); cycle(); cycle();
    wb(1, 5); cycle();
    wb(0, 0); cycle();

    // x0 never pending; WAW on x7.
    pk(12, 0, 0, 0, 0, 0, 1); cycle();
    pk(13, 0, 1, 0, 0, 0, 0); cycle();
    noenq(); cycle();
    pk(14, 0, 0, 0, 0, 7, 1); cycle();
    pk(15, 0, 0, 0, 0, 7, 1); cycle();
    noenq(); cycle(); cycle();
    wb(1, 7); cycle();
    wb(0, 0); cycle();
    wb(1, 7); cycle();
    wb(0, 0);

    // Issue set wins over write-back clear on x9.
    pk(16, 0, 0, 0, 0, 9, 1); cycle();
    noenq(); cycle();
    pk(17, 0, 0, 0, 0, 9, 1); cycle();
    noenq(); wb(1, 9); cycle();
    wb(0, 0);
    pk(18, 9, 1, 0, 0, 0, 0); cycle();
    noenq(); cycle(); cycle();

    // Flush keeps the scoreboard; clear-all empties it.
    iss_ready_i = 1'b0;
    pk(19, 0, 0, 0, 0, 0, 0); cycle();
    pk(20, 0, 0, 0, 0, 0, 0); cycle();
    pk(21, 0, 0, 0, 0, 0, 0);
    flush_i = 1'b1; cycle();
    flush_i = 1'b0; noenq(); cycle();
    pk(22, 0, 0, 9, 1, 0, 0); cycle();
    noenq(); iss_ready_i = 1'b1; cycle(); cycle();
    flush_scoreboard_i = 1'b1; cycle();
    flush_scoreboard_i = 1'b0; cycle();

    // Asynchronous reset with three queued and x4 pending.
    pk(23, 0, 0, 0, 0, 4, 1); cycle();
    noenq(); cycle();
    stall_i = 1'b1;
    for (int i = 24; i <= 26; i++) begin
      pk(i, 4, 1, 0, 0, 0, 0);
      cycle();
    end
    noenq();
    #2;
    rst_i = 1'b0;
    #1;
    q.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    compare();
    stall_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    pk(27, 4, 1, 0, 0, 0, 0); cycle();
    noenq(); cycle();

    // Random traffic over a small register window.
    for (int n = 0; n < 600; n++) begin
      pk(int'($urandom), int'($urandom_range(0, 7)),
         1'($urandom), int'($urandom_range(0, 7)),
         1'($urandom), int'($urandom_range(0, 7)),
         1'($urandom));
      enq_payload_i = {$urandom, $urandom,
                       $urandom, $urandom};
      enq_valid_i        = ($urandom % 3) != 0;
      iss_ready_i        = ($urandom % 4) != 0;
      stall_i            = ($urandom % 8) == 0;
      flush_i            = ($urandom % 40) == 0;
      flush_scoreboard_i = ($urandom % 60) == 0;
      wb(($urandom % 3) == 0,
         int'($urandom_range(0, 7)));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
